// File: rtl/fetch_pkg.sv
// Shared types for the prefetching fetch unit.
//   fetch_state_t : bus-side fetch state
//   fetch_entry_t : one queued instruction {pc, ir, fault}
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Fetch addresses are word aligned; the low two bits are always forced to zero.
  localparam logic [XLEN-1:0] ADR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched instructions between the bus and execute.
// Ports:
//   clk, rst : clock, async active-high reset
//   push/din : write one entry (caller guarantees the queue is not full)
//   pop      : advance the head; ignored when empty
//   flush    : empty the queue; wins over push and pop
//   count    : number of valid entries
//   head     : entry at the read pointer (meaningful only when count != 0)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       din,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush drops everything by catching rd up to wr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !do_pop)      count <= count + CNT_W'(1);
      else if (!push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching instruction fetch unit: issues single-outstanding Wishbone classic
// reads ahead of execute and buffers {PC, IR, fault} in a small queue.
// Ports:
//   clk, rst            : clock, async active-high reset
//   ibus_*              : Wishbone classic master (read only)
//   PC_O, IR_O, fault_o : queue head (valid while execute=1)
//   execute             : queue head valid
//   ins_busy            : execute stalled, head not consumed
//   jump, jump_target   : redirect fetch and flush the queue
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_cyc,
  output logic        ibus_stb,
  output logic        ibus_we,
  output logic [31:0] ibus_adr,
  output logic [31:0] ibus_dat_o,
  input  logic [31:0] ibus_dat_i,
  input  logic        ibus_ack,
  input  logic        ibus_err,
  output logic [31:0] PC_O,
  output logic [31:0] IR_O,
  output logic        fault_o,
  output logic        execute,
  input  logic        ins_busy,
  input  logic        jump,
  input  logic [31:0] jump_target
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t     state;
  logic [31:0]      fpc;
  logic [31:0]      target;
  logic             resp;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_din;
  fetch_entry_t     q_head;

  assign ibus_we    = 1'b0;
  assign ibus_dat_o = '0;

  assign target = jump_target & ADR_MASK;
  // ack together with err is treated as an error response.
  assign resp   = ibus_ack | ibus_err;
  assign push   = (state == REQ) && resp && !jump;
  assign pop    = execute && !ins_busy && !jump;
  assign q_din  = '{pc: fpc, ir: (ibus_err ? 32'h0 : ibus_dat_i), fault: ibus_err};

  assign execute = (q_count != '0);
  assign PC_O    = q_head.pc;
  assign IR_O    = q_head.ir;
  assign fault_o = q_head.fault;

  // Fetch FSM with registered bus outputs; IDLE between transfers gives the cyc gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fpc      <= PC_RESET_VECTOR;
      ibus_cyc <= 1'b0;
      ibus_stb <= 1'b0;
      ibus_adr <= PC_RESET_VECTOR;
    end else begin
      case (state)
        IDLE: begin
          if (jump) begin
            fpc <= target;
          end else if (q_count < CNT_W'(QUEUE_DEPTH)) begin
            state    <= REQ;
            ibus_cyc <= 1'b1;
            ibus_stb <= 1'b1;
            ibus_adr <= fpc;
          end
        end
        REQ: begin
          if (resp) begin
            state    <= IDLE;
            ibus_cyc <= 1'b0;
            ibus_stb <= 1'b0;
            fpc      <= jump ? target : fpc + 32'd4;
          end else if (jump) begin
            // Bus cycle cannot be abandoned; finish it and drop the data.
            state <= DISCARD;
            fpc   <= target;
          end
        end
        DISCARD: begin
          if (jump) fpc <= target;
          if (resp) begin
            state    <= IDLE;
            ibus_cyc <= 1'b0;
            ibus_stb <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ibus_cyc <= 1'b0;
          ibus_stb <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .T     (fetch_entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump),
    .din   (q_din),
    .count (q_count),
    .head  (q_head)
  );

endmodule
